tft_fb_arbiter: RTL and testbench

//  Shares one single-port framebuffer RAM between the TFT panel refresh path and a host port.

---
 rtl/tft_fb_arbiter_pkg.sv | 19 +
 rtl/tft_fb_arbiter_pix_fifo.sv | 56 +++++
 rtl/tft_fb_arbiter.sv | 136 +++++++++++++
 tb/tb_tft_fb_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tft_fb_arbiter_pkg.sv
// Shared types for the TFT framebuffer path: pixel format, read-return tags and
// arbiter states, plus panel geometry defaults used by the timing generator.
package tft_pkg;

  localparam int unsigned H_ACTIVE_DEF = 800;
  localparam int unsigned V_ACTIVE_DEF = 480;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_HOST, TAG_DROP} tag_e;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_e;

  // A frame restart turns outstanding display reads into discards.
  function automatic tag_e retag_on_restart(input tag_e t);
    return (t == TAG_DISP) ? TAG_DROP : t;
  endfunction

endpackage

// File: rtl/tft_fb_arbiter_pix_fifo.sv
// Pixel prefetch FIFO: synchronous, flushable, first-word-fall-through head that
// reads as zero whenever the FIFO is empty.
module tft_pix_fifo
  import tft_pkg::*;
#(
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  pixel_t           wdata,
  input  logic             pop,
  output pixel_t           head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  pixel_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign head   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/tft_fb_arbiter.sv
// Single-port framebuffer arbiter: prefetches the active frame into a pixel FIFO
// for the panel and gives every spare RAM slot to the host, with a starvation bound.
module tft_fb_arbiter
  import tft_pkg::*;
#(
  parameter int unsigned H_ACTIVE      = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE      = V_ACTIVE_DEF,
  parameter int unsigned ADDR_W        = 19,
  parameter int unsigned BASE_ADDR     = 0,
  parameter int unsigned FIFO_DEPTH    = 64,
  parameter int unsigned LOW_WM        = 16,
  parameter int unsigned MEM_LAT       = 2,
  parameter int unsigned HOST_MAX_WAIT = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_frame_start,
  input  logic              i_pix_rd,
  output pixel_t            o_pixel,
  output logic              o_pix_empty,
  output logic              o_underrun,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  pixel_t            i_host_wdata,
  output logic              o_host_gnt,
  output logic              o_host_rvalid,
  output pixel_t            o_host_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output pixel_t            o_mem_wdata,
  input  pixel_t            i_mem_rdata
);

  localparam int unsigned TOTAL  = H_ACTIVE * V_ACTIVE;
  localparam int unsigned FC_W   = $clog2(TOTAL + 1);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + MEM_LAT + 1);
  localparam int unsigned WAIT_W = $clog2(HOST_MAX_WAIT + 1);

  state_e              state;
  logic [FC_W-1:0]     fetch_cnt;
  tag_e                tag_pipe [MEM_LAT];
  logic [WAIT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]    fifo_cnt;
  logic [OCC_W-1:0]    inflight;
  logic [OCC_W-1:0]    occupancy;
  logic [ADDR_W-1:0]   disp_addr;
  logic                room, urgent, starve, prio_disp;
  logic                host_sel, disp_sel, disp_push;
  tag_e                ret_tag;

  // Outstanding display reads count against FIFO space so the FIFO can never overflow.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(MEM_LAT); i++) begin
      if (tag_pipe[i] == TAG_DISP) inflight = inflight + OCC_W'(1);
    end
  end

  assign occupancy = OCC_W'(fifo_cnt) + inflight;
  assign room      = occupancy < OCC_W'(FIFO_DEPTH);
  assign urgent    = (state == S_FETCH) && (occupancy < OCC_W'(LOW_WM));
  assign starve    = wait_cnt >= WAIT_W'(HOST_MAX_WAIT);
  assign prio_disp = urgent && room && !starve && !i_frame_start;
  assign host_sel  = i_rst_n && i_host_req && !prio_disp;
  assign disp_sel  = prio_disp ||
                     ((state == S_FETCH) && room && !i_host_req && !i_frame_start);
  assign disp_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(fetch_cnt);

  assign o_host_gnt  = host_sel;
  assign o_mem_req   = host_sel || disp_sel;
  assign o_mem_we    = host_sel && i_host_we;
  assign o_mem_addr  = host_sel ? i_host_addr : (disp_sel ? disp_addr : '0);
  assign o_mem_wdata = (host_sel && i_host_we) ? i_host_wdata : '0;

  assign ret_tag   = tag_pipe[MEM_LAT-1];
  assign disp_push = (ret_tag == TAG_DISP) && !i_frame_start;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      fetch_cnt <= '0;
    end else if (i_frame_start) begin
      state     <= S_FETCH;
      fetch_cnt <= '0;
    end else if (disp_sel) begin
      fetch_cnt <= fetch_cnt + FC_W'(1);
      if (fetch_cnt == FC_W'(TOTAL - 1)) state <= S_DONE;
    end
  end

  // Tag pipe mirrors the RAM read latency; its last stage names the data on i_mem_rdata.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(MEM_LAT); i++) tag_pipe[i] <= TAG_NONE;
    end else begin
      tag_pipe[0] <= disp_sel ? TAG_DISP :
                     (host_sel && !i_host_we) ? TAG_HOST : TAG_NONE;
      for (int i = 1; i < int'(MEM_LAT); i++) begin
        tag_pipe[i] <= i_frame_start ? retag_on_restart(tag_pipe[i-1]) : tag_pipe[i-1];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_host_rvalid <= 1'b0;
      o_host_rdata  <= '0;
      wait_cnt      <= '0;
      o_underrun    <= 1'b0;
    end else begin
      o_host_rvalid <= (ret_tag == TAG_HOST);
      if (ret_tag == TAG_HOST) o_host_rdata <= i_mem_rdata;
      wait_cnt <= (i_host_req && !host_sel) ? wait_cnt + WAIT_W'(1) : '0;
      if (i_frame_start)                o_underrun <= 1'b0;
      else if (i_pix_rd && o_pix_empty) o_underrun <= 1'b1;
    end
  end

  tft_pix_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .flush (i_frame_start),
    .push  (disp_push),
    .wdata (i_mem_rdata),
    .pop   (i_pix_rd),
    .head  (o_pixel),
    .empty (o_pix_empty),
    .count (fifo_cnt)
  );

endmodule

// File: tb/tb_tft_fb_arbiter.sv
// Directed bench for tft_fb_arbiter on a small panel with a behavioural RAM;
// host reads are scoreboarded, display addresses and pixels checked in order.
module tb_tft_fb_arbiter;

  localparam int H_ACTIVE      = 16;
  localparam int V_ACTIVE      = 12;
  localparam int TOTAL         = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_W        = 10;
  localparam int RAM_WORDS     = 1 << ADDR_W;
  localparam int BASE_ADDR     = 0;
  localparam int FIFO_DEPTH    = 16;
  localparam int LOW_WM        = 4;
  localparam int MEM_LAT       = 2;
  localparam int HOST_MAX_WAIT = 8;

  typedef struct {
    logic [23:0] data;
    int          due;
  } host_exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_start, pix_rd;
  logic [23:0]       pixel;
  logic              pix_empty, underrun;
  logic              host_req, host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [23:0]       host_wdata;
  logic              host_gnt, host_rvalid;
  logic [23:0]       host_rdata;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [23:0]       mem_wdata, mem_rdata;

  logic [23:0]       ram [RAM_WORDS];
  logic [ADDR_W-1:0] rd_pipe [MEM_LAT];
  bit                ram_ready = 1'b0;

  host_exp_t host_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  disp_n = 0;
  int  pix_idx = 0;
  bit  auto_pop = 1'b0;
  bit  last_gnt = 1'b0;

  always #5 clk = ~clk;

  tft_fb_arbiter #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR),
    .FIFO_DEPTH(FIFO_DEPTH), .LOW_WM(LOW_WM), .MEM_LAT(MEM_LAT), .HOST_MAX_WAIT(HOST_MAX_WAIT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start), .i_pix_rd(pix_rd),
    .o_pixel(pixel), .o_pix_empty(pix_empty), .o_underrun(underrun),
    .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr),
    .i_host_wdata(host_wdata), .o_host_gnt(host_gnt), .o_host_rvalid(host_rvalid),
    .o_host_rdata(host_rdata), .o_mem_req(mem_req), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  function automatic logic [23:0] pat(input int a);
    return 24'((a * 32'h0001_0307) ^ 32'h00A5_C3E1);
  endfunction

  // RAM model: data for a read requested in cycle t is on the bus during cycle t+MEM_LAT.
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < RAM_WORDS; i++) ram[i] <= pat(i);
      ram_ready <= 1'b1;
    end else if (mem_req && mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    rd_pipe[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = ram[rd_pipe[MEM_LAT-1]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    host_exp_t e;
    last_gnt = host_gnt;
    if (host_rvalid) begin
      if (host_q.size() == 0) check("host_rvalid_unexpected", 1, 0);
      else begin
        e = host_q.pop_front();
        check("host_rdata", host_rdata, e.data);
        check("host_latency", cyc, e.due);
      end
    end
    if (mem_req && host_gnt) begin
      check("host_mem_addr", mem_addr, host_addr);
      check("host_mem_we", mem_we, host_we);
      // rvalid rises on the MEM_LAT-th edge after the grant edge
      if (!host_we) host_q.push_back('{data: ram[host_addr], due: cyc + MEM_LAT + 1});
    end else if (mem_req) begin
      check("disp_addr", mem_addr, BASE_ADDR + disp_n);
      check("disp_we", mem_we, 0);
      disp_n++;
    end
    if (pix_rd && !pix_empty) begin
      check("pixel", pixel, pat(BASE_ADDR + pix_idx));
      pix_idx++;
    end
    if (frame_start) begin
      disp_n  = 0;
      pix_idx = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (auto_pop) pix_rd = !pix_empty;
    #1;
    observe();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    int reqs, n, w;
    bit seen;
    rst_n = 1'b0; frame_start = 1'b0; pix_rd = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;

    repeat (3) tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_pix_empty", pix_empty, 1);
    check("rst_underrun", underrun, 0);
    check("rst_rvalid", host_rvalid, 0);
    check("rst_pixel", pixel, 0);
    rst_n = 1'b1;
    reqs = 0;
    repeat (5) begin tick(); if (mem_req) reqs++; end
    check("idle_no_req", reqs, 0);

    // Fill the FIFO without popping, then free one slot.
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    repeat (30) tick();
    check("fill_reads", disp_n, FIFO_DEPTH);
    check("fill_stops", mem_req, 0);
    check("fill_not_empty", pix_empty, 0);
    pix_rd = 1'b1; tick(); pix_rd = 1'b0;
    repeat (4) tick();
    check("refill_one", disp_n, FIFO_DEPTH + 1);
    check("refill_stops", mem_req, 0);

    // Underrun is sticky across a refilling FIFO.
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("urun_empty", pix_empty, 1);
    check("urun_pixel_zero", pixel, 0);
    pix_rd = 1'b1; tick(); pix_rd = 1'b0;
    check("urun_set", underrun, 1);
    repeat (10) tick();
    check("urun_sticky", underrun, 1);
    check("urun_refilled", pix_empty, 0);

    // Restart with two display reads outstanding.
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    pix_rd = 1'b1; tick(); pix_rd = 1'b0;
    tick();
    check("restart_inflight", disp_n, 2);
    check("restart_urun_before", underrun, 1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("restart_urun_clear", underrun, 0);
    check("restart_empty0", pix_empty, 1);
    tick();
    check("restart_empty1", pix_empty, 1);
    tick();
    check("restart_empty2", pix_empty, 1);
    tick();
    pix_rd = 1'b1; tick(); pix_rd = 1'b0;
    check("restart_first_pixel", pix_idx, 1);
    check("restart_no_urun", underrun, 0);

    // Asynchronous reset in the middle of a fetch.
    repeat (2) tick();
    check("midfetch_active", mem_req, 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_mem_req", mem_req, 0);
    check("async_pix_empty", pix_empty, 1);
    check("async_pixel", pixel, 0);
    check("async_rvalid", host_rvalid, 0);
    host_q.delete(); disp_n = 0; pix_idx = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    reqs = 0;
    repeat (5) begin tick(); if (mem_req) reqs++; end
    check("post_reset_idle", reqs, 0);

    // Whole frame streamed out once the FIFO has filled.
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    repeat (FIFO_DEPTH + 4) tick();
    auto_pop = 1'b1;
    n = 0;
    while (pix_idx < TOTAL && n < 4 * TOTAL) begin tick(); n++; end
    auto_pop = 1'b0; pix_rd = 1'b0;
    check("frame_pixels", pix_idx, TOTAL);
    check("frame_reads", disp_n, TOTAL);
    reqs = 0;
    repeat (20) begin tick(); if (mem_req) reqs++; end
    check("frame_done_idle", reqs, 0);

    // Host write then read-back while the display is finished.
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'd700; host_wdata = 24'hABCDEF;
    #1;
    check("hw_gnt", host_gnt, 1);
    check("hw_we", mem_we, 1);
    check("hw_wdata", mem_wdata, 24'hABCDEF);
    tick();
    host_we = 1'b0;
    tick();
    host_req = 1'b0;
    repeat (4) tick();
    check("hr_drained", host_q.size(), 0);

    // Popping every cycle keeps the display urgent, so each host read waits the full bound.
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    auto_pop = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'd700;
    w = 0; seen = 1'b0;
    while (!seen && w < 4 * HOST_MAX_WAIT) begin
      tick(); seen = last_gnt; if (!seen) w++;
    end
    check("starve_wait1", w, HOST_MAX_WAIT);
    host_addr = 10'd5;
    w = 0; seen = 1'b0;
    while (!seen && w < 4 * HOST_MAX_WAIT) begin
      tick(); seen = last_gnt; if (!seen) w++;
    end
    check("starve_wait2", w, HOST_MAX_WAIT);
    host_req = 1'b0;
    repeat (6) tick();
    check("starve_drained", host_q.size(), 0);
    auto_pop = 1'b0; pix_rd = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
